div_ctrl: RTL and testbench

Multi-cycle controller that sequences a 16-bit restoring shift-subtract division for the pipeline's DIV/DIVU instructions. It accepts one request at a time from the execute stage and runs one quotient bit per clock. It holds the pipeline via `stall` while busy and leaves quotient/remainder in HI/LO-style result registers until the next division completes. Signed operation, divide-by-zero and pipeline flush are handled internally, so the execute stage only pulses `start`.

---
 rtl/div_ctrl.sv | 174 +++++++++++++++++
 tb/tb_div_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring shift-subtract divider controller for DIV/DIVU.
// One quotient bit per clock; results live in HI/LO-style registers that only
// change on the edge entering DONE (or on reset).
module div_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  // Control and architecturally visible result registers (reset)
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // Working datapath registers (no reset needed; always loaded before use)
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sgn_q, sgn_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;

  // Iteration step signals
  logic [WIDTH+1:0] shift_r;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH:0]   trial;
  logic             trial_ok;

  // Magnitude of a value; the most negative value maps to itself and is then
  // treated as unsigned, which yields the natural-wrap overflow result.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  // Conditional two's-complement negation, modulo 2^WIDTH
  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Shift-subtract step: {r,q} << 1, then try to subtract the divisor magnitude
  always_comb begin
    shift_r  = {r_q, q_q[WIDTH-1]};
    shift_q  = {q_q[WIDTH-2:0], 1'b0};
    trial    = shift_r[WIDTH:0] - {1'b0, dmag_q};
    trial_ok = (shift_r >= {2'b00, dmag_q});
  end

  // Next-state, datapath and result update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dmag_d  = dmag_q;
    r_d     = r_q;
    q_d     = q_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          sgn_d   = is_signed;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (dvs_q == '0) begin
          quot_d  = '1;
          rem_d   = dvd_q;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          q_d     = mag(dvd_q, sgn_q);
          dmag_d  = mag(dvs_q, sgn_q);
          negq_d  = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          negr_d  = sgn_q & dvd_q[WIDTH-1];
          r_d     = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          r_d   = trial_ok ? trial : shift_r[WIDTH:0];
          q_d   = {shift_q[WIDTH-1:1], trial_ok};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          quot_d  = cneg(q_q, negq_q);
          rem_d   = cneg(r_q[WIDTH-1:0], negr_q);
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control/result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working datapath registers
  always_ff @(posedge clk) begin
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
    sgn_q  <= sgn_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
    dmag_q <= dmag_d;
    r_q    <= r_d;
    q_q    <= q_d;
  end

  // Status outputs
  always_comb begin
    busy        = (state_q != S_IDLE);
    stall       = busy | (start & (state_q == S_IDLE));
    done        = (state_q == S_DONE);
    quotient    = quot_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and randomized checks of div_ctrl against a plain
// arithmetic reference model (truncating division, remainder takes dividend sign).
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, stall, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic s, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r, output logic z);
    int sa, sb, ma, mb, qi, ri;
    if (b == 16'h0) begin
      q = 16'hFFFF; r = a; z = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; z = 1'b0;
    end else begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      qi = ma / mb;
      ri = ma % mb;
      if ((sa < 0) != (sb < 0)) qi = -qi;
      if (sa < 0) ri = -ri;
      q = 16'(qi); r = 16'(ri); z = 1'b0;
    end
  endfunction

  // One division: issue start at a negedge, wait for done, compare results.
  // inj >= 0 pulses a different start at that many negedges after acceptance.
  // Returns at the negedge where done is high, so a following call issues
  // start in the cycle right after done.
  task automatic run(input logic s, input logic [15:0] a, input logic [15:0] b,
                     input int inj, input logic fl_at_start);
    logic [15:0] eq, er;
    logic        ez;
    int          n;
    logic        stall_ok;
    model(s, a, b, eq, er, ez);
    @(negedge clk);
    chk("idle_before_start", busy, 0);
    chk("no_done_before_start", done, 0);
    start = 1'b1; is_signed = s; dividend = a; divisor = b; flush = fl_at_start;
    #1 chk("stall_on_start", stall, 1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0; n = 0; stall_ok = 1'b1;
    while (!done && n < 40) begin
      if (!stall || !busy) stall_ok = 1'b0;
      if (n == inj) begin
        start = 1'b1; is_signed = ~s; dividend = a ^ 16'h5A5A; divisor = b + 16'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    // edges after the acceptance edge until done is visible
    chk("done_latency", n, (b == 16'h0) ? 1 : 18);
    chk("stall_while_busy", stall_ok, 1);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, ez);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rs;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    run(1'b0, 16'd100, 16'd7, -1, 1'b0);

    // flush at ITER count 5: no done, results hold
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 16'd1000; divisor = 16'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_quot_hold", quotient, 16'd14);
    chk("flush_rem_hold", remainder, 16'd2);

    run(1'b1, 16'hFFF9, 16'h0002, -1, 1'b0);
    run(1'b1, 16'h8000, 16'hFFFF, -1, 1'b0);
    run(1'b0, 16'hFFFF, 16'h0001, -1, 1'b0);
    run(1'b0, 16'h1234, 16'h0000, -1, 1'b0);
    run(1'b1, 16'h1234, 16'h0000, -1, 1'b0);
    run(1'b0, 16'd9, 16'd3, -1, 1'b0);
    run(1'b0, 16'd1000, 16'd7, 5, 1'b0);
    run(1'b1, 16'h0040, 16'hFFF0, -1, 1'b1);
    run(1'b1, 16'h8000, 16'h0001, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'h0;
        1, 2:    rb = 16'($urandom_range(1, 20));
        default: rb = 16'($urandom);
      endcase
      run(rs, ra, rb, -1, 1'b0);
    end

    // reset mid-ITER with a concurrent start
    run(1'b0, 16'h1234, 16'h0000, -1, 1'b0);
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 16'd500; divisor = 16'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0; start = 1'b1; dividend = 16'd77; divisor = 16'd5;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_quot", quotient, 0);
    chk("midrst_rem", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("rst_start_ignored", busy, 0);

    run(1'b0, 16'd100, 16'd7, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
